// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register.
// The line is synchronized, start edges are detected only while idle,
// every bit is sampled at mid-bit, and the byte is handed off through
// a valid/ready holding register. Errors are reported as single-cycle pulses.
module uart_rx #(
    parameter int CLK    = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int ONEBIT = CLK / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF = ONEBIT / 2;
    // The counter is at least 20 bits wide and always wide enough to hold ONEBIT-1.
    localparam int CW   = ($clog2(ONEBIT) > 20) ? $clog2(ONEBIT) : 20;
    localparam logic [CW-1:0] LAST      = CW'(ONEBIT - 1);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg;
    logic          frame_err_reg;
    logic          overrun_reg;
    // [0] first sync stage, [1] synchronized line, [2] history for edge detect
    logic [2:0]    sync_chain_reg;

    logic rxd_sync;
    logic fall_edge;
    logic sample_pt;
    logic bit_end;
    logic handshake;

    assign rxd_sync  = sync_chain_reg[1];
    assign fall_edge = sync_chain_reg[2] & ~sync_chain_reg[1];
    assign sample_pt = (cnt_reg == SAMPLE_AT);
    assign bit_end   = (cnt_reg == LAST);
    assign handshake = rx_valid_reg & rx_ready;

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

    // Two-flop synchronizer plus a history flop; all reset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_chain_reg <= 3'b111;
        end else begin
            sync_chain_reg <= {sync_chain_reg[1:0], uart_rxd};
        end
    end

    // Receive FSM with bit timing, shift register and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            if (handshake) begin
                rx_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    cnt_reg     <= '0;
                    bit_idx_reg <= 3'd0;
                    if (fall_edge) begin
                        state_reg <= START;
                    end
                end

                START: begin
                    if (sample_pt && rxd_sync) begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (bit_end) begin
                        state_reg   <= DATA;
                        cnt_reg     <= '0;
                        bit_idx_reg <= 3'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                DATA: begin
                    if (sample_pt) begin
                        shift_reg <= {rxd_sync, shift_reg[7:1]};
                    end
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                STOP: begin
                    if (sample_pt) begin
                        // Decide at mid stop bit and return to idle immediately.
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        if (!rxd_sync) begin
                            frame_err_reg <= 1'b1;
                        end else if (!rx_valid_reg || rx_ready) begin
                            // Either empty, or the old byte leaves this very cycle.
                            rx_data_reg  <= shift_reg;
                            rx_valid_reg <= 1'b1;
                        end else begin
                            overrun_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames driven at ONEBIT=16 clocks per bit,
// checked against a byte-level model of the holding register.
module tb_uart_rx;

    localparam int ONEBIT = 16;

    logic       clk;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK   (1600),
        .BAUD  (100),
        .ONEBIT(ONEBIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Observed activity, collected on the falling edge.
    logic [7:0] got_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int valid_cycles = 0;

    // Reference model state.
    logic [7:0] exp_q[$];
    int         fe_exp = 0;
    int         ov_exp = 0;
    bit         model_held = 0;
    logic [7:0] model_data = 8'h00;

    // Monitor: count pulses, valid cycles and accepted bytes.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_delivered(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
        check({tag, "_frame_err"}, fe_cnt, fe_exp);
        check({tag, "_overrun"}, ov_cnt, ov_exp);
    endtask

    // Model of one frame: optional handshake at stop time, then outcome, then drain.
    task automatic model_frame(input logic [7:0] d, input bit stop, input bit rdy_stop, input bit rdy_after);
        if (model_held && rdy_stop) begin
            exp_q.push_back(model_data);
            model_held = 0;
        end
        if (!stop) fe_exp++;
        else if (model_held) ov_exp++;
        else begin
            model_held = 1;
            model_data = d;
        end
        if (rdy_after && model_held) begin
            exp_q.push_back(model_data);
            model_held = 0;
        end
    endtask

    task automatic model_drain();
        if (model_held) begin
            exp_q.push_back(model_data);
            model_held = 0;
        end
    endtask

    // Drive one 8N1 frame. With hs_pulse, rx_ready is high only for the clock edge
    // that samples the stop bit: start-edge sync (3) + start bit (16) + 8 data bits (128)
    // + 8 clocks into the stop bit puts that edge 155 clocks after the start is driven.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit hs_pulse);
        int n;
        n = 0;
        for (int b = 0; b < 10; b++) begin
            if (b == 0) uart_rxd = 1'b0;
            else if (b == 9) uart_rxd = stop;
            else uart_rxd = d[b-1];
            for (int c = 0; c < ONEBIT; c++) begin
                step();
                n++;
                if (hs_pulse && n == 154) rx_ready = 1'b1;
                if (hs_pulse && n == 155) rx_ready = 1'b0;
            end
        end
        uart_rxd = 1'b1;
    endtask

    initial begin
        int vc0;
        logic [7:0] d;
        bit stop;
        bit r;

        rst = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (4) step();
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        step();
        check("release_frame_err", frame_err, 0);
        check("release_overrun", overrun, 0);
        repeat (5) step();

        // Good frame, consumer always ready: one-cycle valid.
        rx_ready = 1'b1;
        vc0 = valid_cycles;
        send_frame(8'h55, 1, 0);
        model_frame(8'h55, 1, 1, 1);
        repeat (4) step();
        check("f55_valid_cycles", valid_cycles - vc0, 1);
        check_delivered("f55");
        $display("frame 0x55 stop=1 ready=1 done");

        // Short low glitch: false start, nothing reported.
        uart_rxd = 1'b0;
        repeat (4) step();
        uart_rxd = 1'b1;
        repeat (40) step();
        check("glitch_rx_valid", rx_valid, 0);
        check_delivered("glitch");
        $display("glitch of 4 clocks done");

        // Bad stop bit.
        send_frame(8'hA3, 0, 0);
        model_frame(8'hA3, 0, 1, 1);
        repeat (4) step();
        check("fA3_rx_valid", rx_valid, 0);
        check_delivered("fA3");
        $display("frame 0xA3 stop=0 done");

        // Overrun with consumer stalled.
        rx_ready = 1'b0;
        send_frame(8'h12, 1, 0);
        model_frame(8'h12, 1, 0, 0);
        repeat (3) step();
        send_frame(8'h34, 1, 0);
        model_frame(8'h34, 1, 0, 0);
        repeat (3) step();
        check("ovr_rx_valid", rx_valid, 1);
        check("ovr_rx_data", rx_data, 8'h12);
        rx_ready = 1'b1;
        step();
        model_drain();
        check("ovr_valid_fall", rx_valid, 0);
        check_delivered("ovr");
        $display("frames 0x12,0x34 with stall done");

        // Handshake exactly on the stop-sample cycle.
        rx_ready = 1'b0;
        send_frame(8'h12, 1, 0);
        model_frame(8'h12, 1, 0, 0);
        repeat (3) step();
        send_frame(8'hC7, 1, 1);
        model_frame(8'hC7, 1, 1, 0);
        repeat (3) step();
        check("hs_rx_valid", rx_valid, 1);
        check("hs_rx_data", rx_data, 8'hC7);
        check_delivered("hs");
        rx_ready = 1'b1;
        step();
        model_drain();
        check("hs_valid_fall", rx_valid, 0);
        check_delivered("hs_drain");
        $display("frame 0xC7 with stop-cycle handshake done");

        // Reset during bit 4 of 0xFF, then a clean 0x81.
        uart_rxd = 1'b0;
        repeat (ONEBIT) step();
        uart_rxd = 1'b1;
        repeat (4 * ONEBIT + 8) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        model_held = 0;
        step();
        check("rstmid_rx_valid", rx_valid, 0);
        repeat (20) step();
        send_frame(8'h81, 1, 0);
        model_frame(8'h81, 1, 1, 1);
        repeat (4) step();
        check_delivered("rstmid");
        $display("reset mid-frame then 0x81 done");

        // Randomized frames against the model.
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 1));
            if (r && !rx_ready) begin
                rx_ready = 1'b1;
                step();
                model_drain();
            end
            rx_ready = r;
            send_frame(d, stop, 0);
            model_frame(d, stop, r, r);
            repeat ($urandom_range(2, 20)) step();
            check("rand_rx_valid", rx_valid, model_held);
            if (model_held) check("rand_rx_data", rx_data, model_data);
            check_delivered("rand");
            $display("random frame %0d data=%02h stop=%0d ready=%0d", k, d, stop, r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter ONEBIT, default CLK/BAUD, clocks per bit; HALF = ONEBIT/2 is derived internally.
REQ-004 clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 uart_rxd  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 rx_data  output  8  received byte, valid while rx_valid=1.
REQ-008 rx_valid  output  1  byte available.
REQ-009 rx_ready  input  1  consumer accepts; transfer occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: a good frame completed while the holding register was still full.

Function
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer plus one history flop, all reset to 1; a start edge is synchronized high->low.
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-014 Bit-timing counter SHALL run 0..ONEBIT-1 only outside IDLE, clear on wrap, and clear on every state entry.
REQ-015 Sample point SHALL be counter==HALF-1 in every non-IDLE state.
REQ-016 IDLE->START SHALL occur on a synchronized falling edge.
REQ-017 START, sample=1: SHALL return to IDLE (false start) with no output activity.
REQ-018 START, sample=0: SHALL go to DATA at counter wrap.
REQ-019 DATA SHALL sample 8 bits LSB first into a shift register, using a 3-bit bit index 0..7.
REQ-020 DATA SHALL go to STOP at the wrap after bit 7.
REQ-021 STOP SHALL evaluate at its sample point and then go to IDLE on the next cycle, without waiting for the full stop bit.
REQ-022 Stop sample=1 with rx_valid=0: the shift register SHALL load into rx_data and rx_valid SHALL rise on the next cycle, i.e. 1 cycle after the stop sample.
REQ-023 Stop sample=0: frame_err SHALL pulse for 1 cycle, the byte is discarded, and rx_data/rx_valid SHALL be unchanged.
REQ-024 Stop sample=1 with rx_valid=1 and no handshake that cycle: overrun SHALL pulse for 1 cycle, the new byte is dropped and the old byte is kept.
REQ-025 Stop sample=1 on the same cycle as a handshake: the new byte SHALL load, rx_valid SHALL remain 1, and overrun SHALL stay 0.
REQ-026 rx_valid SHALL hold with rx_data stable until a handshake, then fall the next cycle.
REQ-027 rx_ready SHALL have no effect while rx_valid=0.
REQ-028 Line activity in DATA/STOP SHALL NOT restart the FSM; edges are only detected in IDLE.
REQ-029 Counter width SHALL hold ONEBIT-1 for all legal parameters, minimum 20 bits; ONEBIT>=4 is required.

Reset
REQ-030 On rst=1 at a clock edge: FSM=IDLE, counters=0, synchronizer/history=1, shift register=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait in IDLE for the next falling edge.
REQ-032 No output pulse SHALL be generated in the cycle reset releases, even if uart_rxd=0.

Verification (CLK=1600, BAUD=100, ONEBIT=16)
REQ-033 Frame 0x55 with good stop and rx_ready=1 -> rx_data=8'h55, rx_valid high exactly 1 cycle, frame_err=0, overrun=0.
REQ-034 Low glitch of 4 clocks in idle -> FSM back to IDLE after the START sample; no rx_valid, no frame_err.
REQ-035 Frame 0xA3 with stop bit driven 0 -> frame_err one pulse, rx_valid stays 0.
REQ-036 rx_ready=0; frames 0x12 then 0x34 -> rx_data stays 8'h12, overrun pulses once; raising rx_ready -> rx_valid falls next cycle.
REQ-037 rx_ready pulsed on the exact stop-sample cycle of a second frame 0xC7 while 0x12 is held -> rx_data becomes 8'hC7, rx_valid stays 1, no overrun.
REQ-038 rst=1 asserted during bit 4 of 0xFF, then a full frame 0x81 -> only 8'h81 delivered; no error pulses.
